coi2_conv_ctrl: RTL and testbench
=================================

# coi2_conv_ctrl

Conversion sequencer for the second-order cascade-of-integrators (CoI2) decimation filter that follows the delta-sigma modulator. On each conversion it clears the filter, gates exactly OSR modulator bits into it, waits out the filter's two-register pipeline, and captures the 32-bit result into a valid/ready output register. It supports single-shot and continuous conversion, abort, and sticky overrun reporting. It sits between the ADC register interface and the CoI2 filter instance.

## Interface
- CNT_W, 16: OSR counter width. Full-scale result osr*(osr+1)/2 must fit 32 bits.
- DATA_W, 32: filter output and result width.

- clk  in  1  system/ADC clock; the filter shares it.
- rst_adc  in  1  reset, asynchronous, active-high; clock clk.
- start  in  1  one-cycle conversion request; ignored while busy.
- stop  in  1  abort request; takes priority over start in the same cycle.
- cont  in  1  continuous mode, sampled with start.
- osr  in  CNT_W  bits per conversion, latched at accepted start.
- bit_in  in  1  raw modulator bitstream.
- filt_din  out  1  gated bitstream to filter: bit_in & gate.
- filt_clr  out  1  registered clear, ORed into the filter's reset at top level.
- filt_dout  in  DATA_W  filter output.
- res_data  out  DATA_W  captured conversion result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; set when an unread result is overwritten.

## Operation
- States: IDLE, CLEAR, INTEG, SETTLE, CAPTURE.
- IDLE: gate=0, filt_clr=0. start & !stop -> CLEAR; latch osr_q = max(osr,2), cont_q = cont; clear overrun.
- CLEAR (1 cycle): filt_clr=1, gate=0 -> INTEG, counter=0.
- INTEG (osr_q cycles): gate=1; counter increments; last count -> SETTLE.
- SETTLE (1 cycle): gate=0 -> CAPTURE.
- CAPTURE (1 cycle): gate=0; res_data <= filt_dout at the edge ending this cycle; res_valid <= 1. If res_valid was already 1 and not being accepted this cycle, set overrun. Then -> CLEAR if cont_q, else IDLE.
- res_valid clears on the edge where res_valid & res_ready, unless CAPTURE loads in the same cycle; load wins and overrun is not set.
- stop in any non-IDLE state: -> IDLE next edge, gate=0, filt_clr=0; no capture; res_valid/res_data unchanged.
- start while busy: ignored; osr changes mid-conversion are ignored.
- Result arithmetic: with bits b0..bN-1 gated, result = sum over k of (N-k)*bk; all-ones gives N(N+1)/2. No saturation is needed within CNT_W=16.
- rst_adc: state=IDLE; counter, osr_q, cont_q, res_data=0; res_valid, overrun, filt_clr, busy=0; filt_din=0.

## Timing
- Accepted start at cycle t: CLEAR at t+1, where filt_clr=1 and the filter is held at 0. INTEG runs t+2..t+osr_q+1.
- Filter is two registers deep. The final value appears during CAPTURE, at t+osr_q+3.
- res_valid is first high at t+osr_q+4. Single-shot latency is osr_q+4 cycles from start.
- Continuous period is osr_q+3 cycles per result (CLEAR+INTEG+SETTLE+CAPTURE).
- busy rises the cycle after start and falls the cycle after CAPTURE, or after stop.
- filt_clr is registered and glitch-free, exactly 1 cycle wide.

## Test plan
- Single-shot: osr=4, bit_in=1 constant, res_ready=0. Required: res_data=10, res_valid high 8 cycles after start, busy low afterward, filt_clr pulsed once.
- Pattern: osr=8, bit_in alternating starting with 1. Required: res_data=20; with bit_in=0 constant, res_data=0.
- Continuous: osr=4, all ones, res_ready=1. Required: result 10 every 7 cycles, overrun=0. Then hold res_ready=0 across two captures. Required: overrun=1 and res_data holds the latest value; a new start clears overrun.
- Abort: stop in mid-INTEG, osr=16. Required: IDLE next cycle, filt_din=0, no res_valid change. A later start gives a correct fresh result (136 for all ones).
- Edge cases: osr=0 and osr=1 with all ones give 3 (clamped to 2). start while busy is ignored. start & stop together stays IDLE.
- Reset: assert rst_adc mid-INTEG with res_valid=1. Required: all outputs 0 immediately. After release, the controller stays idle until start.

Source files
------------

// File: rtl/coi2_conv_ctrl.sv
// Conversion sequencer for the CoI2 decimation filter.
// Each conversion clears the filter, gates osr modulator bits into it,
// lets the two-register filter pipeline settle, then captures the result
// into a valid/ready output register.
//
// Handshake: res_data is stable while res_valid is high; the result is
// consumed on an edge where res_valid & res_ready. A capture in that same
// cycle reloads the register and wins, with no overrun. A capture that
// lands on an unread result (res_valid high, res_ready low) overwrites it
// and sets the sticky overrun flag.
module coi2_conv_ctrl #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_adc,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [CNT_W-1:0]  osr,
  input  logic              bit_in,
  output logic              filt_din,
  output logic              filt_clr,
  input  logic [DATA_W-1:0] filt_dout,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    INTEG   = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             gate;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] osr_q;
  logic             cont_q;
  logic             accept;
  logic             last_bit;
  logic             capture;

  // A start is honoured only from IDLE, and stop always beats it.
  assign accept   = (state_q == IDLE) && start && !stop;
  assign last_bit = (cnt_q == (osr_q - CNT_W'(1)));
  // An abort during CAPTURE suppresses the load.
  assign capture  = (state_q == CAPTURE) && !stop;

  assign busy     = (state_q != IDLE);
  assign filt_din = bit_in & gate;

  // Next-state and gate decode; abort from any active state returns to IDLE.
  always_comb begin
    state_d = state_q;
    gate    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = INTEG;
      end
      INTEG: begin
        gate = 1'b1;
        if (last_bit) state_d = SETTLE;
      end
      SETTLE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = cont_q ? CLEAR : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      gate    = 1'b0;
    end
  end

  // State register plus the registered, single-cycle filter clear.
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      state_q  <= IDLE;
      filt_clr <= 1'b0;
    end else begin
      state_q  <= state_d;
      filt_clr <= (state_d == CLEAR);
    end
  end

  // Bit counter: zeroed in CLEAR, advances once per gated bit.
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q <= '0;
    end else if (state_q == INTEG) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Conversion parameters latched at an accepted start; osr is clamped to 2.
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      osr_q  <= '0;
      cont_q <= 1'b0;
    end else if (accept) begin
      osr_q  <= (osr < CNT_W'(2)) ? CNT_W'(2) : osr;
      cont_q <= cont;
    end
  end

  // Result register with valid/ready handshake; a load beats a consume.
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      res_data  <= '0;
      res_valid <= 1'b0;
    end else if (capture) begin
      res_data  <= filt_dout;
      res_valid <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky overrun: set when a capture overwrites an unread result,
  // cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst_adc) begin
    if (rst_adc) begin
      overrun <= 1'b0;
    end else if (accept) begin
      overrun <= 1'b0;
    end else if (capture && res_valid && !res_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_coi2_conv_ctrl.sv
// Bench for coi2_conv_ctrl: a behavioural CoI2 filter plant feeds filt_dout,
// and expected results come from the closed-form weighted bit sum over the
// logged modulator bits of each conversion window.
module tb_coi2_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst_adc;
  logic        start;
  logic        stop;
  logic        cont;
  logic [15:0] osr;
  logic        bit_in;
  logic        filt_din;
  logic        filt_clr;
  logic [31:0] filt_dout;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = 1;   // 0 zeros, 1 ones, 2 alternating from first INTEG bit, 3 random
  int t_start  = 0;
  logic bit_log [0:8191];
  logic [31:0] exp_q[$];

  coi2_conv_ctrl #(.CNT_W(16), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_adc   (rst_adc),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .osr       (osr),
    .bit_in    (bit_in),
    .filt_din  (filt_din),
    .filt_clr  (filt_clr),
    .filt_dout (filt_dout),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Filter plant: two cascaded integrators, cleared by reset or filt_clr.
  logic        flt_rst;
  logic [31:0] i1;
  logic [31:0] i2;
  assign flt_rst   = rst_adc | filt_clr;
  assign filt_dout = i2;
  always @(posedge clk or posedge flt_rst) begin
    if (flt_rst) begin
      i1 <= '0;
      i2 <= '0;
    end else begin
      i1 <= i1 + {31'd0, filt_din};
      i2 <= i2 + i1;
    end
  end

  // Reference: result = sum_k (N-k)*b_k over the N bits following CLEAR.
  function automatic logic [31:0] ref_result(input int clr_cyc, input int n);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++)
      if (bit_log[clr_cyc + 1 + k]) acc = acc + 32'(n - k);
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: advance to the next negedge, drive this cycle's bit, log it.
  task automatic tick();
    @(negedge clk);
    case (mode)
      0: bit_in = 1'b0;
      1: bit_in = 1'b1;
      2: bit_in = (cyc >= t_start + 2) && (((cyc - t_start - 2) % 2) == 0);
      default: bit_in = 1'($urandom_range(0, 1));
    endcase
    bit_log[cyc] = bit_in;
    #1;
  endtask

  task automatic drain();
    if (res_valid) begin
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  // One single-shot conversion with timing, clear-pulse and result checks.
  task automatic do_single(input logic [15:0] o, input int m, input logic [31:0] exp_const,
                           input bit use_const, input bit poke, input string tag);
    int n;
    int lat;
    int clrs;
    int t0;
    logic [31:0] expv;
    drain();
    mode    = m;
    t0      = cyc;
    t_start = t0;
    start   = 1'b1;
    cont    = 1'b0;
    osr     = o;
    n       = (o < 16'd2) ? 2 : int'(o);
    lat     = -1;
    clrs    = 0;
    for (int i = 1; i <= n + 12; i++) begin
      tick();
      if (i == 1) begin
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_clr_at_t1"}, {31'd0, filt_clr}, 32'd1);
        chk({tag, "_ovr_clr"}, {31'd0, overrun}, 32'd0);
        start = 1'b0;
        osr   = 16'($urandom_range(0, 40));
      end
      if (i == 2) chk({tag, "_din_gated"}, {31'd0, filt_din}, {31'd0, bit_in});
      if (poke && i == 4) begin start = 1'b1; cont = 1'b1; end
      if (poke && i == 5) begin start = 1'b0; cont = 1'b0; end
      if (filt_clr) clrs++;
      if (res_valid && lat < 0) lat = i;
    end
    expv = ref_result(t0 + 1, n);
    exp_q.push_back(expv);
    chk({tag, "_latency"}, 32'(lat), 32'(n + 4));
    chk({tag, "_clr_pulses"}, 32'(clrs), 32'd1);
    chk({tag, "_data_model"}, res_data, exp_q.pop_front());
    if (use_const) chk({tag, "_data_const"}, res_data, exp_const);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_held"}, {31'd0, res_valid}, 32'd1);
  endtask

  initial begin
    int t0;
    int j;
    bit cap;
    rst_adc   = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cont      = 1'b0;
    osr       = 16'd0;
    bit_in    = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 8192; i++) bit_log[i] = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_clr", {31'd0, filt_clr}, 32'd0);
    chk("rst_din", {31'd0, filt_din}, 32'd0);
    rst_adc = 1'b0;
    repeat (2) tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // start & stop together stays idle
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", {31'd0, busy}, 32'd0);
    chk("startstop_clr", {31'd0, filt_clr}, 32'd0);

    // Directed single-shot conversions
    do_single(16'd4, 1, 32'd10, 1'b1, 1'b0, "ss_osr4");
    do_single(16'd8, 2, 32'd20, 1'b1, 1'b0, "alt_osr8");
    do_single(16'd8, 0, 32'd0, 1'b1, 1'b0, "zero_osr8");
    do_single(16'd0, 1, 32'd3, 1'b1, 1'b0, "osr0");
    do_single(16'd1, 1, 32'd3, 1'b1, 1'b0, "osr1");
    do_single(16'd6, 1, 32'd21, 1'b1, 1'b1, "busy_start");

    // Randomized single-shot conversions
    for (int r = 0; r < 4; r++)
      do_single(16'($urandom_range(2, 20)), 3, 32'd0, 1'b0, (r == 1), "rand");

    // Continuous mode, then starve the consumer across two captures
    drain();
    mode      = 1;
    res_ready = 1'b1;
    start     = 1'b1;
    cont      = 1'b1;
    osr       = 16'd4;
    t0        = cyc;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i == 1) begin start = 1'b0; cont = 1'b0; end
      cap = (i >= 8) && (((i - 8) % 7) == 0);
      j   = (i - 8) / 7;
      if (i <= 22) chk("cont_valid", {31'd0, res_valid}, {31'd0, cap});
      if (cap) chk("cont_data_model", res_data, ref_result(t0 + 1 + j * 7, 4));
      if (cap && j <= 2) chk("cont_data_10", res_data, 32'd10);
      if (i == 22) chk("cont_no_ovr", {31'd0, overrun}, 32'd0);
      if (i == 29) chk("cont_ovr_first", {31'd0, overrun}, 32'd0);
      if (i == 36) begin
        chk("cont_ovr_set", {31'd0, overrun}, 32'd1);
        chk("cont_valid_held", {31'd0, res_valid}, 32'd1);
      end
      if (i == 23) begin res_ready = 1'b0; mode = 3; end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_idle", {31'd0, busy}, 32'd0);
    chk("cont_stop_ovr_kept", {31'd0, overrun}, 32'd1);
    chk("cont_stop_valid_kept", {31'd0, res_valid}, 32'd1);
    do_single(16'd4, 1, 32'd10, 1'b1, 1'b0, "after_ovr");

    // Abort mid-INTEG with osr=16; previous result (10) must survive
    mode  = 1;
    start = 1'b1;
    cont  = 1'b0;
    osr   = 16'd16;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) start = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_din", {31'd0, filt_din}, 32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd1);
    chk("abort_data", res_data, 32'd10);
    repeat (24) tick();
    chk("abort_valid_later", {31'd0, res_valid}, 32'd1);
    chk("abort_data_later", res_data, 32'd10);
    do_single(16'd16, 1, 32'd136, 1'b1, 1'b0, "after_abort");

    // Asynchronous reset mid-INTEG with a result pending
    mode  = 1;
    start = 1'b1;
    osr   = 16'd16;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) start = 1'b0;
    end
    rst_adc = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_data", res_data, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    chk("arst_clr", {31'd0, filt_clr}, 32'd0);
    chk("arst_din", {31'd0, filt_din}, 32'd0);
    tick();
    rst_adc = 1'b0;
    repeat (6) tick();
    chk("arst_stays_idle", {31'd0, busy}, 32'd0);
    chk("arst_no_clr", {31'd0, filt_clr}, 32'd0);
    chk("arst_no_valid", {31'd0, res_valid}, 32'd0);
    do_single(16'($urandom_range(2, 12)), 3, 32'd0, 1'b0, 1'b0, "final_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
